// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forward control and divider sequencing for the 5-stage pipe
module pipeline_hazard_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_d,
    input  logic [4:0] rt_d,
    input  logic       branch_d,
    input  logic [4:0] rs_e,
    input  logic [4:0] rt_e,
    input  logic [4:0] writereg_e,
    input  logic       regwrite_e,
    input  logic       memtoreg_e,
    input  logic [4:0] writereg_m,
    input  logic       regwrite_m,
    input  logic       memtoreg_m,
    input  logic [4:0] writereg_w,
    input  logic       regwrite_w,
    input  logic       div_start_e,
    input  logic       imem_stall,
    input  logic       dmem_stall,
    input  logic       exc_m,
    output logic       pc_en,
    output logic       en_fd,
    output logic       en_de,
    output logic       en_em,
    output logic       en_mw,
    output logic       flush_fd,
    output logic       flush_de,
    output logic       flush_em,
    output logic       flush_mw,
    output logic [1:0] fwd_a_e,
    output logic [1:0] fwd_b_e,
    output logic       fwd_a_d,
    output logic       fwd_b_d,
    output logic       div_busy,
    output logic       div_done
);
    localparam int CW = (DIV_CYCLES > 2) ? $clog2(DIV_CYCLES - 1) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_stall, div_stall, lw_stall, br_stall;

    function automatic logic hit(input logic we, input logic [4:0] w, input logic [4:0] r);
        return we && (w != 5'd0) && (w == r);
    endfunction

    assign mem_stall = imem_stall | dmem_stall;
    assign lw_stall  = hit(memtoreg_e & regwrite_e, writereg_e, rs_d) |
                       hit(memtoreg_e & regwrite_e, writereg_e, rt_d);
    assign br_stall  = branch_d & (hit(regwrite_e, writereg_e, rs_d) | hit(regwrite_e, writereg_e, rt_d) |
                                   hit(memtoreg_m, writereg_m, rs_d) | hit(memtoreg_m, writereg_m, rt_d));

    // Divider state register; reset aborts any divide in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Divider next state: count down the busy window, hold DONE while memory stalls
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (exc_m) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (div_start_e) begin
                    state_d = BUSY;
                    cnt_d   = CW'(DIV_CYCLES - 2);
                end
                BUSY: if (cnt_q == '0) state_d = DONE;
                      else cnt_d = cnt_q - CW'(1);
                DONE: if (!mem_stall) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Divider outputs; the start cycle itself already stalls so the bubble is DIV_CYCLES long
    always_comb begin
        div_busy  = state_q != IDLE;
        div_done  = state_q == DONE;
        div_stall = (state_q == IDLE && div_start_e) || state_q == BUSY;
    end

    // Enable/flush priority: exception squash, memory freeze, divide bubble, hazard bubble, run
    always_comb begin
        {pc_en, en_fd, en_de, en_em, en_mw}        = 5'b11111;
        {flush_fd, flush_de, flush_em, flush_mw}   = 4'b0000;
        if (exc_m && !dmem_stall) begin
            {flush_fd, flush_de, flush_em, flush_mw} = 4'b1111;
        end else if (mem_stall) begin
            {pc_en, en_fd, en_de, en_em, en_mw} = 5'b00000;
        end else if (div_stall) begin
            {pc_en, en_fd, en_de} = 3'b000;
            flush_em = 1'b1;
        end else if (lw_stall || br_stall) begin
            {pc_en, en_fd} = 2'b00;
            flush_de = 1'b1;
        end
    end

    // Operand forwarding, M result preferred over W
    always_comb begin
        fwd_a_e = hit(regwrite_m, writereg_m, rs_e) ? 2'b10 :
                  hit(regwrite_w, writereg_w, rs_e) ? 2'b01 : 2'b00;
        fwd_b_e = hit(regwrite_m, writereg_m, rt_e) ? 2'b10 :
                  hit(regwrite_w, writereg_w, rt_e) ? 2'b01 : 2'b00;
        fwd_a_d = hit(regwrite_m, writereg_m, rs_d);
        fwd_b_d = hit(regwrite_m, writereg_m, rt_d);
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: randomized scoreboard bench for the hazard controller
module tb_pipeline_hazard_ctrl;
    localparam int DC = 32;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w;
    logic       branch_d, regwrite_e, memtoreg_e, regwrite_m, memtoreg_m, regwrite_w;
    logic       div_start_e, imem_stall, dmem_stall, exc_m;
    logic       pc_en, en_fd, en_de, en_em, en_mw;
    logic       flush_fd, flush_de, flush_em, flush_mw;
    logic [1:0] fwd_a_e, fwd_b_e;
    logic       fwd_a_d, fwd_b_d, div_busy, div_done;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset),
        .rs_d(rs_d), .rt_d(rt_d), .branch_d(branch_d),
        .rs_e(rs_e), .rt_e(rt_e),
        .writereg_e(writereg_e), .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e),
        .writereg_m(writereg_m), .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m),
        .writereg_w(writereg_w), .regwrite_w(regwrite_w),
        .div_start_e(div_start_e), .imem_stall(imem_stall), .dmem_stall(dmem_stall), .exc_m(exc_m),
        .pc_en(pc_en), .en_fd(en_fd), .en_de(en_de), .en_em(en_em), .en_mw(en_mw),
        .flush_fd(flush_fd), .flush_de(flush_de), .flush_em(flush_em), .flush_mw(flush_mw),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e), .fwd_a_d(fwd_a_d), .fwd_b_d(fwd_b_d),
        .div_busy(div_busy), .div_done(div_done)
    );

    typedef struct {
        logic [8:0] ctl;
        logic [5:0] fwd;
        logic [1:0] dv;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;
    int   m_left = 0;
    bit   m_done = 1'b0;

    function automatic bit hit(input logic we, input logic [4:0] w, input logic [4:0] r);
        return we && w != 5'd0 && w == r;
    endfunction

    function automatic logic [1:0] fsel(input logic [4:0] r);
        if (hit(regwrite_m, writereg_m, r)) return 2'b10;
        if (hit(regwrite_w, writereg_w, r)) return 2'b01;
        return 2'b00;
    endfunction

    task automatic issue();
        exp_t e;
        bit ms, dstall, lw, br;
        if (reset) begin
            m_left = 0;
            m_done = 1'b0;
        end
        ms     = imem_stall | dmem_stall;
        dstall = m_left > 0 || (!m_done && div_start_e);
        lw     = hit(memtoreg_e & regwrite_e, writereg_e, rs_d) || hit(memtoreg_e & regwrite_e, writereg_e, rt_d);
        br     = branch_d && (hit(regwrite_e, writereg_e, rs_d) || hit(regwrite_e, writereg_e, rt_d) ||
                              hit(memtoreg_m, writereg_m, rs_d) || hit(memtoreg_m, writereg_m, rt_d));
        if (exc_m && !dmem_stall) e.ctl = 9'b11111_1111;
        else if (ms)              e.ctl = 9'b00000_0000;
        else if (dstall)          e.ctl = 9'b00011_0010;
        else if (lw || br)        e.ctl = 9'b00111_0100;
        else                      e.ctl = 9'b11111_0000;
        e.fwd = {fsel(rs_e), fsel(rt_e), 1'(hit(regwrite_m, writereg_m, rs_d)), 1'(hit(regwrite_m, writereg_m, rt_d))};
        e.dv  = {1'(m_left > 0 || m_done), 1'(m_done)};
        e.cyc = cyc;
        sb.push_back(e);
        if (!reset) begin
            if (exc_m) begin
                m_left = 0;
                m_done = 1'b0;
            end else if (m_done) begin
                m_done = ms;
            end else if (m_left > 0) begin
                m_left = m_left - 1;
                m_done = (m_left == 0);
            end else if (div_start_e) begin
                m_left = DC - 1;
            end
        end
    endtask

    task automatic tick();
        issue();
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        {rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w} = '0;
        {branch_d, regwrite_e, memtoreg_e, regwrite_m, memtoreg_m, regwrite_w} = '0;
        {div_start_e, imem_stall, dmem_stall, exc_m} = '0;
    endtask

    task automatic chk(input string n, input int c, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s cyc=%0d got=%b exp=%b", n, c, got, exp);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                chk("ctl", e.cyc, {pc_en, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, flush_em, flush_mw}, e.ctl);
                chk("fwd", e.cyc, {3'b000, fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d}, {3'b000, e.fwd});
                chk("div", e.cyc, {7'b0, div_busy, div_done}, {7'b0, e.dv});
            end
        end
    end

    initial begin : driver
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();
        // load-use on rs_d
        memtoreg_e = 1'b1; regwrite_e = 1'b1; writereg_e = 5'd2; rs_d = 5'd2;
        tick();
        clear_inputs();
        tick();
        // forwarding M over W, then W only, then $0
        regwrite_m = 1'b1; writereg_m = 5'd5; rs_e = 5'd5; rt_e = 5'd5; regwrite_w = 1'b1; writereg_w = 5'd5;
        tick();
        writereg_m = 5'd0;
        tick();
        writereg_w = 5'd0;
        tick();
        clear_inputs();
        repeat (3) tick();
        // divide with data-memory wait overlapping the end of the stall
        for (int i = 0; i <= 40; i++) begin
            div_start_e = (i <= 35);
            dmem_stall  = (i >= 30 && i <= 35);
            tick();
        end
        clear_inputs();
        tick();
        // exception during a busy divide with a load-use hazard present
        div_start_e = 1'b1;
        repeat (5) tick();
        div_start_e = 1'b0; exc_m = 1'b1;
        memtoreg_e = 1'b1; regwrite_e = 1'b1; writereg_e = 5'd3; rt_d = 5'd3;
        tick();
        clear_inputs();
        repeat (2) tick();
        // exception held behind a data-memory wait
        div_start_e = 1'b1;
        repeat (5) tick();
        div_start_e = 1'b0; exc_m = 1'b1; dmem_stall = 1'b1;
        repeat (3) tick();
        dmem_stall = 1'b0;
        tick();
        clear_inputs();
        repeat (2) tick();
        // asynchronous reset in the middle of a divide
        div_start_e = 1'b1;
        repeat (8) tick();
        div_start_e = 1'b0;
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (40) tick();
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rs_d        = 5'($urandom_range(0, 3));
            rt_d        = 5'($urandom_range(0, 3));
            rs_e        = 5'($urandom_range(0, 3));
            rt_e        = 5'($urandom_range(0, 3));
            writereg_e  = 5'($urandom_range(0, 3));
            writereg_m  = 5'($urandom_range(0, 3));
            writereg_w  = 5'($urandom_range(0, 3));
            branch_d    = 1'($urandom_range(0, 2) == 0);
            regwrite_e  = 1'($urandom_range(0, 1));
            memtoreg_e  = 1'($urandom_range(0, 1));
            regwrite_m  = 1'($urandom_range(0, 1));
            memtoreg_m  = 1'($urandom_range(0, 1));
            regwrite_w  = 1'($urandom_range(0, 1));
            div_start_e = 1'($urandom_range(0, 99) < 6);
            imem_stall  = 1'($urandom_range(0, 99) < 10);
            dmem_stall  = 1'($urandom_range(0, 99) < 10);
            exc_m       = 1'($urandom_range(0, 99) < 3);
            reset       = 1'($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0;
        clear_inputs();
        @(negedge clk);
        #5;
        checks++;
        if (sb.size() == 0) passed++;
        else $display("FAIL drain left=%0d required=0", sb.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
